// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the d_ff_pipe register pipeline.
//   PIPE_RESET_VAL_DEFAULT : default data value loaded on reset and on flush
//   clog2_occ(stages)      : bit width needed to count 0..stages valid stages
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int PIPE_RESET_VAL_DEFAULT = 0;

  // occupancy has to reach STAGES itself, hence STAGES+1 distinct values
  function automatic int clog2_occ(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/d_ff_pipe_stage.sv
// ---------------------------------------------------------------------------
// d_ff_pipe_stage
// One slice of the d_ff_pipe pipeline: a valid bit plus a WIDTH-bit data
// register.
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active-low
//   flush     : synchronous clear (v=0, data=RESET_VAL)
//   adv       : this stage loads from its source on this edge
//   src_valid : valid bit of the source (in_valid or the previous stage)
//   src_data  : data of the source
//   v         : registered valid bit
//   data      : registered data word
// ---------------------------------------------------------------------------
module d_ff_pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             adv,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             v,
  output logic [WIDTH-1:0] data
);

  // The data register only captures when a valid word lands here, so bubbles
  // passing through do not toggle the data flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v    <= 1'b0;
      data <= RESET_VAL;
    end else if (flush) begin
      v    <= 1'b0;
      data <= RESET_VAL;
    end else if (adv) begin
      v <= src_valid;
      if (src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/d_ff_pipe.sv
// ---------------------------------------------------------------------------
// d_ff_pipe
// Valid/ready register pipeline, WIDTH bits wide and STAGES deep, in which
// bubbles collapse: an empty stage keeps loading while a later stage stalls.
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active-low
//   flush     : synchronous clear of every stage and of occupancy
//   in_valid  : producer offers in_data
//   in_ready  : pipeline accepts in_data this cycle
//   in_data   : input word
//   out_valid : last stage holds a valid word
//   out_ready : consumer takes out_data this cycle
//   out_data  : data register of the last stage
//   occupancy : registered count of valid stages
// ---------------------------------------------------------------------------
module d_ff_pipe
  import pipe_pkg::*;
#(
  parameter  int               WIDTH     = 8,
  parameter  int               STAGES    = 4,
  parameter  logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL_DEFAULT),
  localparam int               OCC_W     = clog2_occ(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  data [STAGES];
  logic              in_xfer;
  logic              out_xfer;

  // A stage may load when it is empty or when its successor moves on too.
  // Built from the output back to the input; in_valid never enters this chain.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !v[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = !v[i] | adv[i+1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (i == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = v[i-1];
      assign src_data  = data[i-1];
    end

    d_ff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .adv       (adv[i]),
      .src_valid (src_valid),
      .src_data  (src_data),
      .v         (v[i]),
      .data      (data[i])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = v[STAGES-1];
  assign out_data  = data[STAGES-1];

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Simultaneous input and output transfers cancel, so the count stays
  // within 0..STAGES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

endmodule

// File: tb/tb_d_ff_pipe.sv
// ---------------------------------------------------------------------------
// tb_d_ff_pipe
// Bench for d_ff_pipe (WIDTH=8, STAGES=4, RESET_VAL=8'hA5, 10 ns clock).
// The reference model keeps the words in flight as a queue ordered oldest
// first, each tagged with the stage position it occupies.
// ---------------------------------------------------------------------------
module tb_d_ff_pipe;

  localparam int         WIDTH  = 8;
  localparam int         STAGES = 4;
  localparam logic [7:0] RV     = 8'hA5;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] occupancy;

  d_ff_pipe #(
    .WIDTH     (WIDTH),
    .STAGES    (STAGES),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    int         pos;
  } word_t;

  word_t q[$];
  bit    mv[STAGES];
  bit    clean;
  bit    seen7e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which words move forward on the coming edge: the oldest leaves only if
  // the consumer takes it; any other word moves unless it sits directly
  // behind a word that is stuck.
  function automatic void calc_moves(input bit ordy);
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].pos == STAGES - 1)                       mv[k] = ordy;
      else if (k > 0 && q[k-1].pos == q[k].pos + 1)     mv[k] = mv[k-1];
      else                                              mv[k] = 1'b1;
    end
  endfunction

  function automatic bit model_ready();
    if (q.size() == 0) return 1'b1;
    if (q[q.size()-1].pos != 0) return 1'b1;
    return mv[q.size()-1];
  endfunction

  function automatic void model_clear();
    q.delete();
    clean = 1'b1;
  endfunction

  // one clock: drive inputs, compare against the model, take the edge
  task automatic step(input bit iv, input logic [7:0] id, input bit ordy,
                      input bit fl, output bit acc);
    bit    mir;
    bit    exp_v;
    word_t nq[$];
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    calc_moves(ordy);
    mir   = model_ready();
    exp_v = (q.size() > 0) && (q[0].pos == STAGES - 1);
    chk("in_ready", 32'(in_ready), 32'(mir));
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    if (exp_v)      chk("out_data", 32'(out_data), 32'(q[0].d));
    else if (clean) chk("out_data_rst", 32'(out_data), 32'(RV));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    if (out_valid === 1'b1 && out_data === 8'h7E) seen7e = 1'b1;
    acc = iv && mir && !fl;
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      for (int k = 0; k < q.size(); k++) begin
        word_t w;
        w = q[k];
        if (w.pos == STAGES - 1 && mv[k]) continue;
        if (mv[k]) w.pos++;
        if (w.pos == STAGES - 1) clean = 1'b0;
        nq.push_back(w);
      end
      if (iv && mir) nq.push_back('{d: id, pos: 0});
      q = nq;
    end
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'(RV));
    chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    bit         acc;
    logic [7:0] nw;
    logic [7:0] w5;

    clk       = 1'b1;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    seen7e    = 1'b0;
    model_clear();

    // 1: reset held for 15 ns, sampled mid-cycle and around an edge
    #2  chk_reset_outputs("rst_mid");
    #7  chk_reset_outputs("rst_pre_edge");
    #2  chk_reset_outputs("rst_post_edge");
    #4  rst = 1'b1;

    // 2: streaming at full rate
    nw = 8'h01;
    for (int c = 0; c < 12; c++) begin
      step(1'b1, nw, 1'b1, 1'b0, acc);
      if (acc) nw++;
    end
    for (int c = 0; c < 5; c++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("stream_drained_occ", 32'(occupancy), 32'd0);

    // 3: backpressure, then drain while the 5th word waits
    nw = 8'h21;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, nw, 1'b0, 1'b0, acc);
      if (acc) nw++;
    end
    chk("bp_full_occ", 32'(occupancy), 32'd4);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    w5 = nw;
    step(1'b1, w5, 1'b1, 1'b0, acc);
    chk("bp_5th_accepted", 32'(acc), 32'd1);
    for (int c = 0; c < 6; c++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // 4: bubbles collapse under a stalled output
    step(1'b1, 8'h41, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    step(1'b1, 8'h42, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    chk("bubble_occ", 32'(occupancy), 32'd2);
    chk("bubble_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 6; c++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // 5: flush with three words in flight and 7E offered
    step(1'b1, 8'h61, 1'b0, 1'b0, acc);
    step(1'b1, 8'h62, 1'b0, 1'b0, acc);
    step(1'b1, 8'h63, 1'b0, 1'b0, acc);
    step(1'b1, 8'h7E, 1'b0, 1'b1, acc);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_data", 32'(out_data), 32'(RV));
    for (int c = 0; c < 6; c++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("flush_7e_never_out", 32'(seen7e), 32'd0);

    // 6: asynchronous reset between edges in mid-stream
    nw = 8'h81;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, nw, 1'b1, 1'b0, acc);
      if (acc) nw++;
    end
    #2 rst = 1'b0;
    #1 chk_reset_outputs("async_rst");
    model_clear();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    nw = 8'h91;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, nw, 1'b1, 1'b0, acc);
      if (acc) nw++;
    end

    // randomized traffic with occasional flush
    for (int c = 0; c < 300; c++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0), acc);
    end
    for (int c = 0; c < 6; c++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("final_empty_occ", 32'(occupancy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
